axi_ex_monitor: RTL

Exclusive-access reservation monitor for the AXI subordinate pair. It arms one reservation context per AXI ID when the read subordinate accepts an exclusive (ARLOCK) read, and exports `ex_active` and `ex_ctx` to the write subordinate. The write subordinate uses these to decide whether an exclusive write succeeds (EXOKAY), and returns its registered `ex_clr` vector to disarm any context its writes touched.

---
 rtl/axi_ex_monitor.sv | 94 +++++++++
 1 files changed

// File: rtl/axi_ex_monitor.sv
`default_nettype none
// ============================================================================
// Module   : axi_ex_monitor
// Purpose  : Exclusive-access reservation monitor shared by the AXI read and
//            write subordinates. An exclusive read accepted by the read side
//            arms one reservation context per AXI ID. The write side reads the
//            armed contexts to decide EXOKAY and returns a clear vector that
//            disarms any context its writes touched.
// Ports    : clk, rst_n          - clock, async active-low reset
//            ex_set_valid/id/addr/size/len - exclusive read request (pulse)
//            ex_clr              - per-context disarm from the write side
//            ex_active           - per-context armed flags
//            ex_ctx              - per-context {addr, addr_mask}, AW bits each
//                                  (addr in the upper AW bits)
//            ex_set_err          - one-cycle pulse, last request was illegal
// Revision : 1.0 - initial release
// ============================================================================
module axi_ex_monitor #(
    parameter int AW = 32,
    parameter int IW = 1,
    localparam int ID_NUM = 1 << IW
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ex_set_valid,
    input  logic [IW-1:0]                 ex_set_id,
    input  logic [AW-1:0]                 ex_set_addr,
    input  logic [2:0]                    ex_set_size,
    input  logic [7:0]                    ex_set_len,
    input  logic [ID_NUM-1:0]             ex_clr,
    output logic [ID_NUM-1:0]             ex_active,
    output logic [ID_NUM-1:0][2*AW-1:0]   ex_ctx,
    output logic                          ex_set_err
);

    // Largest legal exclusive burst in bytes.
    localparam logic [15:0] c_bc_max = 16'd128;

    logic [15:0]               w_bc;
    logic [15:0]               w_bc_m1;
    logic [AW-1:0]             w_low;
    logic [AW-1:0]             w_mask;
    logic                      w_legal;
    logic                      w_arm;

    logic [ID_NUM-1:0]         r_active;
    logic [ID_NUM-1:0][2*AW-1:0] r_ctx;
    logic                      r_err;

    // Byte count is held at 16 bits so that no size/len combination wraps;
    // only len < 16 is ever legal, so the interesting values stay small.
    assign w_bc    = (16'd1 << ex_set_size) * (16'(ex_set_len) + 16'd1);
    assign w_bc_m1 = w_bc - 16'd1;

    // Low-offset bits are extended to the address width before inversion so
    // the mask has all upper address bits set.
    assign w_low   = AW'(w_bc_m1);
    assign w_mask  = ~w_low;

    // A power of two has no bits in common with itself minus one.
    assign w_legal = (ex_set_len < 8'd16) &&
                     (w_bc != 16'd0) &&
                     ((w_bc & w_bc_m1) == 16'd0) &&
                     (w_bc <= c_bc_max) &&
                     ((ex_set_addr & w_low) == '0);

    assign w_arm   = ex_set_valid && w_legal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= '0;
            r_ctx    <= '0;
            r_err    <= 1'b0;
        end else begin
            r_err <= ex_set_valid && !w_legal;
            for (int j = 0; j < ID_NUM; j++) begin
                if (ex_clr[j]) begin
                    r_active[j] <= 1'b0;
                end
            end
            // Placed after the clears so a same-cycle set on the same ID wins.
            if (w_arm) begin
                r_active[ex_set_id] <= 1'b1;
                r_ctx[ex_set_id]    <= {ex_set_addr & w_mask, w_mask};
            end
        end
    end

    assign ex_active  = r_active;
    assign ex_ctx     = r_ctx;
    assign ex_set_err = r_err;

endmodule
`default_nettype wire
